// File: rtl/rotary_accum.sv
// Rotary encoder position accumulator with direction-aware acceleration,
// wrap/saturate arithmetic and a two-digit multiplexed hex display.
module rotary_accum #(
   parameter int ACCEL_WINDOW = 500000,
   parameter int SCAN_DIV     = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rot_cw,
   input  logic       rot_ccw,
   input  logic       wrap_en,
   input  logic       clear,
   output logic [7:0] pos,
   output logic       changed,
   output logic [6:0] hex_seg,
   output logic [1:0] hex_an
);

   localparam int GW = $clog2(ACCEL_WINDOW + 1);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'(ACCEL_WINDOW);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      CW_RUN,
      CCW_RUN
   } accel_state_t;

   accel_state_t  state;
   logic [GW-1:0] gap;
   logic [SW-1:0] scan_cnt;
   logic          digit_sel;

   logic          accept_cw;
   logic          accept_ccw;
   logic          fast;
   logic [3:0]    step;
   logic [8:0]    sum;
   logic [8:0]    diff;
   logic [7:0]    pos_next;
   logic          digit_next;
   logic [3:0]    nibble;

   // Standard active-low hex glyphs, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Next position, step size and next display digit; simultaneous cw+ccw
   // cancels out, and clear overrides any pulse
   always_comb begin
      accept_cw  = rot_cw & ~rot_ccw & ~clear;
      accept_ccw = rot_ccw & ~rot_cw & ~clear;
      fast       = (gap < GAP_MAX) &&
                   ((accept_cw && state == CW_RUN) || (accept_ccw && state == CCW_RUN));
      step       = fast ? 4'd4 : 4'd1;
      sum        = {1'b0, pos} + {5'b0, step};
      diff       = {1'b0, pos} - {5'b0, step};
      pos_next   = pos;
      if (clear) begin
         pos_next = '0;
      end else if (accept_cw) begin
         pos_next = (sum[8] && !wrap_en) ? 8'hFF : sum[7:0];
      end else if (accept_ccw) begin
         pos_next = (diff[8] && !wrap_en) ? 8'h00 : diff[7:0];
      end
      digit_next = (scan_cnt == SCAN_LAST) ? ~digit_sel : digit_sel;
      nibble     = digit_next ? pos_next[7:4] : pos_next[3:0];
   end

   // Acceleration FSM and gap counter; a both-high cycle freezes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gap   <= GAP_MAX;
      end else if (clear) begin
         state <= IDLE;
         gap   <= GAP_MAX;
      end else if (accept_cw) begin
         state <= CW_RUN;
         gap   <= '0;
      end else if (accept_ccw) begin
         state <= CCW_RUN;
         gap   <= '0;
      end else if (!(rot_cw && rot_ccw)) begin
         if (gap == GAP_MAX) begin
            state <= IDLE;
         end else begin
            gap <= gap + 1'b1;
         end
      end
   end

   // Position register and one-cycle change strobe aligned with the new value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos     <= '0;
         changed <= 1'b0;
      end else begin
         pos     <= pos_next;
         changed <= (pos_next != pos);
      end
   end

   // Digit scan and registered display outputs, glyph tracks the new position
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_sel <= 1'b0;
         hex_an    <= 2'b10;
         hex_seg   <= 7'b1000000;
      end else begin
         scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
         digit_sel <= digit_next;
         hex_an    <= digit_next ? 2'b01 : 2'b10;
         hex_seg   <= hex_glyph(nibble);
      end
   end

endmodule

// File: tb/tb_rotary_accum.sv
// Scoreboard bench for rotary_accum: a driver issues per-cycle stimulus and
// pushes expectations from a behavioural model; a monitor pops and compares.
module tb_rotary_accum;

   localparam int ACCEL_WINDOW = 8;
   localparam int SCAN_DIV     = 4;

   logic       clk;
   logic       rst;
   logic       rotCw;
   logic       rotCcw;
   logic       wrapEn;
   logic       clear;
   logic [7:0] pos;
   logic       changed;
   logic [6:0] hexSeg;
   logic [1:0] hexAn;

   rotary_accum #(
      .ACCEL_WINDOW(ACCEL_WINDOW),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rot_cw(rotCw),
      .rot_ccw(rotCcw),
      .wrap_en(wrapEn),
      .clear(clear),
      .pos(pos),
      .changed(changed),
      .hex_seg(hexSeg),
      .hex_an(hexAn)
   );

   typedef struct {
      logic [7:0] pos;
      logic [1:0] an;
      logic [6:0] seg;
   } cycleExp_t;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] chgQ[$];
   cycleExp_t  cycQ[$];
   logic [6:0] glyph[16];

   int mPos;
   bit runValid;
   bit lastCw;
   int sinceLast;
   int scanEdges;
   bit wrapSel;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_pos"}, 32'(pos), 32'h0);
      checkOutput({tag, "_changed"}, 32'(changed), 32'h0);
      checkOutput({tag, "_hex_an"}, 32'(hexAn), 32'h2);
      checkOutput({tag, "_hex_seg"}, 32'(hexSeg), 32'h40);
   endtask

   task automatic modelReset();
      mPos      = 0;
      runValid  = 1'b0;
      lastCw    = 1'b0;
      sinceLast = 0;
      scanEdges = 0;
   endtask

   // One clock of stimulus; the model predicts what the following edge shows
   task automatic applyStimulus(input bit cw, input bit ccw, input bit clr);
      int        newPos;
      int        step;
      int        raw;
      int        digit;
      cycleExp_t e;
      @(negedge clk);
      rst    = 1'b0;
      rotCw  = cw;
      rotCcw = ccw;
      clear  = clr;
      wrapEn = wrapSel;
      newPos = mPos;
      if (clr) begin
         newPos   = 0;
         runValid = 1'b0;
      end else if (cw && ccw) begin
         newPos = mPos;
      end else if (cw || ccw) begin
         step = (runValid && lastCw == cw && sinceLast < ACCEL_WINDOW) ? 4 : 1;
         raw  = cw ? mPos + step : mPos - step;
         if (wrapSel) newPos = (raw + 256) % 256;
         else newPos = (raw > 255) ? 255 : ((raw < 0) ? 0 : raw);
         runValid  = 1'b1;
         lastCw    = cw;
         sinceLast = 0;
      end else begin
         sinceLast++;
      end
      if (newPos != mPos) chgQ.push_back(8'(newPos));
      mPos = newPos;
      scanEdges++;
      digit = (scanEdges / SCAN_DIV) % 2;
      e.pos = 8'(mPos);
      e.an  = (digit == 1) ? 2'b01 : 2'b10;
      e.seg = glyph[(digit == 1) ? (mPos / 16) : (mPos % 16)];
      cycQ.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset mid-cycle, with pulses offered while it is held
   task automatic midReset();
      @(posedge clk);
      #3;
      checkOutput("queue_empty_before_reset", 32'(chgQ.size()), 32'h0);
      rst    = 1'b1;
      rotCw  = 1'b1;
      rotCcw = 1'b0;
      clear  = 1'b0;
      #1;
      checkResetValues("async_reset");
      modelReset();
      chgQ.delete();
      cycQ.delete();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pulse_lost_in_reset", 32'(pos), 32'h0);
      rotCw = 1'b0;
   endtask

   // Monitor: compare the change strobe against the change queue and the
   // per-cycle outputs against the cycle queue
   initial begin
      cycleExp_t e;
      logic [7:0] expPos;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            if (changed) begin
               if (chgQ.size() == 0) begin
                  checkOutput("changed_unexpected", 32'(changed), 32'h0);
               end else begin
                  expPos = chgQ.pop_front();
                  checkOutput("changed_pos", 32'(pos), 32'(expPos));
               end
            end
            if (cycQ.size() > 0) begin
               e = cycQ.pop_front();
               checkOutput("pos", 32'(pos), 32'(e.pos));
               checkOutput("hex_an", 32'(hexAn), 32'(e.an));
               checkOutput("hex_seg", 32'(hexSeg), 32'(e.seg));
            end
         end
      end
   end

   // Directed scenarios, randomized traffic, display hold and mid-run reset
   initial begin
      glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      rst     = 1'b1;
      rotCw   = 1'b0;
      rotCcw  = 1'b0;
      clear   = 1'b0;
      wrapSel = 1'b1;
      wrapEn  = 1'b1;
      modelReset();
      repeat (2) @(negedge clk);
      #1;
      checkResetValues("reset");

      $display("[TB] slow single steps");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         idle(19);
      end

      $display("[TB] fast step, then cw+ccw together is ignored");
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(20);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(2);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      idle(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(2);

      $display("[TB] clear beats a pulse, clear at zero is silent");
      applyStimulus(1'b1, 1'b0, 1'b1);
      idle(1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      idle(2);

      $display("[TB] acceleration run and reversal");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         idle(2);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      idle(2);

      $display("[TB] saturate versus wrap at the top");
      applyStimulus(1'b0, 1'b0, 1'b1);
      idle(10);
      applyStimulus(1'b0, 1'b1, 1'b0);
      idle(10);
      applyStimulus(1'b0, 1'b1, 1'b0);
      wrapSel = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      wrapSel = 1'b1;
      idle(10);
      applyStimulus(1'b0, 1'b1, 1'b0);
      idle(10);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(2);

      $display("[TB] saturate at the bottom");
      wrapSel = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      idle(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      idle(2);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 39) == 0) wrapSel = ~wrapSel;
         if (r < 30) applyStimulus(1'b1, 1'b0, 1'b0);
         else if (r < 55) applyStimulus(1'b0, 1'b1, 1'b0);
         else if (r < 58) applyStimulus(1'b1, 1'b1, 1'b0);
         else if (r < 60) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b1);
         else idle($urandom_range(1, 10));
      end

      $display("[TB] hold 0xA5 on the display");
      wrapSel = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 41; i++) begin
         idle(1);
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      idle(16);
      checkOutput("held_pos", 32'(pos), 32'hA5);

      $display("[TB] asynchronous reset mid-run");
      applyStimulus(1'b1, 1'b0, 1'b0);
      midReset();
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(2);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(4);

      @(posedge clk);
      #3;
      checkOutput("change_queue_drained", 32'(chgQ.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
